// File: rtl/spi_sevenseg_master.sv
// spi_sevenseg_master: FIFO-fed MSB-first serialiser for 6-bit seven-segment command frames,
// holding ss low for exactly six edges per frame and high for GAP_CYCLES edges between frames.
module spi_sevenseg_master #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_cmd,
  input  logic [3:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       frame_done,
  output logic       mosi,
  output logic       ss
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    sh_q, sh_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic          mosi_q, mosi_d, ss_q, ss_d, fd_q, fd_d, ovf_q, ovf_d;
  logic          push, pop;
  assign full       = cnt_q == CNT_FULL;
  assign empty      = cnt_q == '0;
  assign busy       = state_q != IDLE;
  assign overflow   = ovf_q;
  assign frame_done = fd_q;
  assign mosi       = mosi_q;
  assign ss         = ss_q;
  // full is taken from the registered count, so a push while full is dropped even if a pop shares the edge
  assign push   = wr_en && !full;
  assign ovf_d  = wr_en && full;
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
  assign wptr_d = wptr_q + AW'(push);
  assign rptr_d = rptr_q + AW'(pop);
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    mosi_d   = mosi_q;
    ss_d     = ss_q;
    fd_d     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      SHIFT: begin
        if (bitcnt_q == 3'd5) begin
          ss_d     = 1'b1;
          mosi_d   = 1'b0;
          fd_d     = 1'b1;
          gapcnt_d = GW'(1);
          state_d  = GAP;
        end else begin
          sh_d     = {sh_q[3:0], 1'b0};
          mosi_d   = sh_q[4];
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      GAP: begin
        if (gapcnt_q == GAP_END) begin
          pop     = !empty;
          state_d = IDLE;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a pop starts a frame: first bit goes out now, the rest wait in the shifter
    if (pop) begin
      sh_d     = mem_q[rptr_q][4:0];
      mosi_d   = mem_q[rptr_q][5];
      ss_d     = 1'b0;
      bitcnt_d = 3'd0;
      state_d  = SHIFT;
    end
  end
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      mosi_q   <= 1'b0;
      ss_q     <= 1'b1;
      fd_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      mosi_q   <= mosi_d;
      ss_q     <= ss_d;
      fd_q     <= fd_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge sclk) begin
    if (push) mem_q[wptr_q] <= {wr_cmd, wr_data};
  end
endmodule

// File: tb/tb_spi_sevenseg_master.sv
// tb_spi_sevenseg_master: scoreboard bench; u[0] uses GAP_CYCLES=1, u[1] uses GAP_CYCLES=3.
module tb_spi_sevenseg_master;
  logic       sclk = 1'b0, rst_n = 1'b0;
  logic [1:0] wr_en = '0, wr_cmd = '0;
  logic [3:0] wr_data = '0;
  logic [1:0] full, empty, busy, overflow, frame_done, mosi, ss;
  int n_checks = 0, n_fail = 0;
  logic [13:0] q0[$], q1[$];
  int gap_exp[2] = '{0, 0};
  int ovf_cnt[2] = '{0, 0};
  int nb[2] = '{0, 0};
  int gap[2] = '{0, 0};
  logic [5:0] rx[2];
  always #5 sclk = ~sclk;
  for (genvar g = 0; g < 2; g++) begin : u
    spi_sevenseg_master #(.DEPTH(4), .GAP_CYCLES(g == 0 ? 1 : 3)) dut (
      .sclk(sclk), .rst_n(rst_n), .wr_en(wr_en[g]), .wr_cmd(wr_cmd), .wr_data(wr_data),
      .full(full[g]), .empty(empty[g]), .busy(busy[g]), .overflow(overflow[g]),
      .frame_done(frame_done[g]), .mosi(mosi[g]), .ss(ss[g])
    );
  end
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference seven-segment slave: {dp, gfedcba}, malformed commands light dp only
  function automatic logic [7:0] seg_of(logic [5:0] f);
    logic [6:0] s;
    case (f[3:0])
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return f[5:4] == 2'b10 ? {1'b0, s} : f[5:4] == 2'b01 ? {1'b1, s} : 8'h80;
  endfunction
  // monitor: the slave samples on posedge what was set on the previous posedge, so sample on negedge
  always @(negedge sclk) begin
    for (int k = 0; k < 2; k++) begin
      if (overflow[k]) ovf_cnt[k]++;
      if (!rst_n) begin
        nb[k] = 0;
        gap[k] = 0;
      end else if (!ss[k]) begin
        if (nb[k] == 0 && gap_exp[k] != 0) check($sformatf("gap_len%0d", k), gap[k], gap_exp[k]);
        check($sformatf("fd_low%0d", k), int'(frame_done[k]), 0);
        rx[k] = {rx[k][4:0], mosi[k]};
        nb[k]++;
      end else begin
        if (nb[k] != 0) begin
          logic [13:0] e;
          check($sformatf("frame_len%0d", k), nb[k], 6);
          check($sformatf("frame_done%0d", k), int'(frame_done[k]), 1);
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame%0d: got 0x%0h expected no frame", k, rx[k]);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("frame_bits%0d", k), int'(rx[k]), int'(e[5:0]));
            check($sformatf("slave_out%0d", k), int'(seg_of(rx[k])), int'(e[13:6]));
          end
          gap[k] = 0;
        end
        gap[k]++;
        nb[k] = 0;
      end
    end
  end
  task automatic push(int k, logic [1:0] c, logic [3:0] d, logic [7:0] seg, bit acc);
    wr_en[k] = 1'b1;
    wr_cmd = c;
    wr_data = d;
    if (acc) begin
      if (k == 0) q0.push_back({seg, c, d});
      else q1.push_back({seg, c, d});
    end
    @(negedge sclk);
    wr_en[k] = 1'b0;
  endtask
  task automatic wait_idle(int k);
    int t = 0;
    while (!(busy[k] == 1'b0 && empty[k] == 1'b1) && t < 300) begin
      @(negedge sclk);
      t++;
    end
    check($sformatf("idle_reached%0d", k), int'(t < 300), 1);
  endtask
  task automatic wait_nf(int k);
    int t = 0;
    while (full[k] && t < 300) begin
      @(negedge sclk);
      t++;
    end
    check($sformatf("room_reached%0d", k), int'(t < 300), 1);
  endtask
  initial begin
    repeat (2) @(negedge sclk);
    check("reset_state0", int'({ss[0], mosi[0], empty[0], full[0], busy[0], frame_done[0], overflow[0]}), 'h50);
    check("reset_state1", int'({ss[1], mosi[1], empty[1], full[1], busy[1], frame_done[1], overflow[1]}), 'h50);
    rst_n = 1'b1;
    @(negedge sclk);
    push(0, 2'b10, 4'h3, 8'h4F, 1);
    check("pre_pop", int'({busy[0], empty[0], ss[0]}), 1);
    @(negedge sclk);
    check("post_pop", int'({busy[0], empty[0], ss[0]}), 6);
    wait_idle(0);
    push(0, 2'b01, 4'h8, 8'hFF, 1);
    wait_idle(0);
    push(0, 2'b00, 4'h5, 8'h80, 1);
    wait_idle(0);
    check("single_no_ovf", ovf_cnt[0], 0);
    push(0, 2'b10, 4'h0, 8'h3F, 1);
    push(0, 2'b10, 4'h1, 8'h06, 1);
    push(0, 2'b10, 4'h2, 8'h5B, 1);
    push(0, 2'b01, 4'h4, 8'hE6, 1);
    push(0, 2'b10, 4'h7, 8'h07, 1);
    gap_exp[0] = 1;
    check("burst_full", int'(full[0]), 1);
    check("burst_no_ovf", ovf_cnt[0], 0);
    repeat (4) @(negedge sclk);
    check("burst_room", int'(full[0]), 0);
    push(0, 2'b10, 4'h9, 8'h6F, 1);
    push(0, 2'b10, 4'hB, 8'h7C, 0);
    @(negedge sclk);
    check("ovf_once", ovf_cnt[0], 1);
    check("still_full", int'(full[0]), 1);
    wait_nf(0);
    push(0, 2'b10, 4'hC, 8'h39, 1);
    wait_nf(0);
    push(0, 2'b10, 4'hD, 8'h5E, 1);
    wait_idle(0);
    gap_exp[0] = 0;
    check("burst_ovf_total", ovf_cnt[0], 1);
    push(0, 2'b10, 4'hE, 8'h79, 1);
    push(0, 2'b10, 4'hF, 8'h71, 1);
    push(0, 2'b01, 4'h1, 8'h86, 1);
    gap_exp[0] = 1;
    repeat (5) @(negedge sclk);
    push(0, 2'b10, 4'h6, 8'h7D, 1);
    check("pp_count2", int'({full[0], empty[0]}), 0);
    push(0, 2'b10, 4'h9, 8'h6F, 1);
    check("pp_count3", int'(full[0]), 0);
    push(0, 2'b10, 4'hB, 8'h7C, 1);
    check("pp_count4", int'(full[0]), 1);
    push(0, 2'b10, 4'h0, 8'h3F, 0);
    @(negedge sclk);
    check("pp_ovf", ovf_cnt[0], 2);
    wait_idle(0);
    gap_exp[0] = 0;
    push(1, 2'b10, 4'h5, 8'h6D, 1);
    push(1, 2'b10, 4'h6, 8'h7D, 1);
    @(negedge sclk);
    gap_exp[1] = 3;
    wait_idle(1);
    gap_exp[1] = 0;
    push(0, 2'b10, 4'h1, 8'h06, 1);
    push(0, 2'b10, 4'h2, 8'h5B, 1);
    push(0, 2'b10, 4'h3, 8'h4F, 1);
    @(negedge sclk);
    rst_n = 1'b0;
    q0.delete();
    @(negedge sclk);
    check("rst_abort", int'({ss[0], mosi[0], empty[0], busy[0]}), 'hA);
    rst_n = 1'b1;
    @(negedge sclk);
    push(0, 2'b10, 4'hA, 8'h77, 1);
    wait_idle(0);
    repeat (2) @(negedge sclk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_sevenseg_master.md
Name: spi_sevenseg_master

Overview:
Serial transmitter for the 6-bit seven-segment command protocol: it drives the mosi/ss pair consumed by the seven-segment SPI slave.
- Host logic pushes {cmd[1:0], nibble[3:0]} words into a small FIFO.
- The block serialises each word MSB-first with ss low for exactly 6 sclk edges, then raises ss for a programmable gap so the slave's bit counter resynchronises.
- It shares sclk with the slave: mosi/ss update on posedge sclk, and the slave samples them on the following posedge.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
GAP_CYCLES, 1, posedges ss is held high between frames (>=1)

Ports:
sclk  input  1  serial/system clock; all state updates on posedge
rst_n  input  1  reset: synchronous, active-low, sampled on posedge sclk
wr_en  input  1  push request
wr_cmd  input  2  command: 2'b10 digit, 2'b01 digit+dp, others = malformed (sent unchanged)
wr_data  input  4  hex nibble
full  output  1  FIFO count == DEPTH (registered count)
empty  output  1  FIFO count == 0
busy  output  1  state != IDLE
overflow  output  1  1-cycle pulse: wr_en while full, word dropped
frame_done  output  1  1-cycle pulse on the edge ss returns high after bit 0
mosi  output  1  serial data, registered
ss  output  1  slave select, active-low, registered

Behaviour:
- Reset (rst_n=0 at posedge) overrides all other activity, including a frame in progress: ss=1, mosi=0, FIFO emptied (pointers and count 0), state IDLE, bit counter 0, gap counter 0, frame_done=0, overflow=0. A truncated frame is abandoned, not resumed.
- Frame word: F = {wr_cmd, wr_data}; sent bit order is F[5], F[4], ..., F[0].
- FIFO push: on wr_en && !full, store F. On wr_en && full, drop the word and pulse overflow. full is evaluated before any same-edge pop, so a push while full is dropped even if a pop occurs on that edge.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both operations occur.
- States:
  - IDLE: ss=1. If !empty at an edge (call it L): pop, load shift register with F, set mosi<=F[5], ss<=0, bitcnt<=0, go to SHIFT. A word pushed at edge E into an empty FIFO pops at E+1 at the earliest.
  - SHIFT: the slave samples one bit at each edge L+1..L+6. At edges L+1..L+5, mosi<=next bit (F[4]..F[0]) and bitcnt increments. At edge L+6, after bit 0 is sampled: ss<=1, mosi<=0, frame_done pulse, gapcnt<=1, go to GAP.
  - GAP: ss=1. At each edge with gapcnt < GAP_CYCLES, increment gapcnt. At the edge where gapcnt == GAP_CYCLES: if !empty, perform an IDLE-style load (back-to-back frame); else go to IDLE.
- Minimum frame period is 7 + GAP_CYCLES - 1 edges (7 with GAP_CYCLES=1). The slave sees ss=1 on at least GAP_CYCLES edges between frames.
- ss is never low for more or fewer than 6 consecutive edges, except when interrupted by reset.
- busy=1 in SHIFT and GAP. empty/full are derived combinationally from the registered count.
- The FIFO accepts pushes in every state; pointers wrap modulo DEPTH.

Test Plan:
- Reset, push cmd=10 data=4'h3 → edges L+1..L+6 sample mosi 1,0,0,0,1,1 with ss=0; ss=1 at L+6; frame_done one pulse; attached slave out=8'h4F.
- Push cmd=01 data=4'h8 → mosi 0,1,1,0,0,0; slave out=8'hFF. Push cmd=00 data=4'h5 → slave out=8'h80 (malformed word forwarded untouched).
- Push 5 words on consecutive edges while idle, DEPTH=4 → first word pops at edge 2, so all 5 are accepted (no overflow). Then push 4 more mid-frame into 3 occupied slots → exactly one overflow pulse. All accepted frames go out back-to-back, each separated by exactly 1 ss-high edge (GAP_CYCLES=1).
- GAP_CYCLES=3, two queued words → ss high for exactly 3 edges between frames; second frame's bits correct.
- Assert rst_n=0 at edge L+3 with 2 words queued → ss=1, mosi=0, empty=1, busy=0 next edge. The slave then receives a fresh pushed word 10/4'hA correctly (out=8'h77).
- Push and pop on the same edge with count=2 → count stays 2, and both words are later transmitted in order.
